hdmi_island_scheduler: RTL and testbench

Sequences HDMI data-island periods inside horizontal blanking and shares packet slots between up to NUM_REQ packet sources (ACR, audio sample, InfoFrames). Runs in the clk_pixel domain alongside the hdmi core and watches its cx counter. Drives the period mode, per-packet grant and intra-packet cycle index that the TERC4 and packet-assembly logic use.

---
 rtl/hdmi_island_scheduler_if.sv | 14 +
 rtl/hdmi_island_scheduler.sv | 145 ++++++++++++++
 tb/tb_hdmi_island_scheduler.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/hdmi_island_scheduler_if.sv
// hdmi_island_scheduler_if: horizontal position and packet requests in, island timing and grants out
interface hdmi_island_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [9:0]         cx;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [NUM_REQ-1:0] grant;
  logic [2:0]         mode;
  logic [4:0]         packet_cycle;
  logic               busy;
  modport master (output cx, req, input ack, grant, mode, packet_cycle, busy);
  modport slave (input cx, req, output ack, grant, mode, packet_cycle, busy);
endinterface

// File: rtl/hdmi_island_scheduler.sv
// hdmi_island_scheduler: sequences data islands in hblank and round-robins packet slots between sources
module hdmi_island_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int FRAME_WIDTH   = 800,
  parameter int ISLAND_START  = 644,
  parameter int ISLAND_END    = 778,
  parameter int MAX_PACKETS   = 18,
  parameter int PACKET_CYCLES = 32
) (
  input logic                   clk_pixel,
  input logic                   reset,
  hdmi_island_scheduler_if.slave bus
);
  localparam int AVAIL = (ISLAND_END - ISLAND_START - 12) / PACKET_CYCLES;
  localparam int FIT = MAX_PACKETS < AVAIL ? MAX_PACKETS : AVAIL;
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam logic [9:0] START = 10'(ISLAND_START);
  localparam logic [4:0] FIT_N = 5'(FIT);
  localparam logic [4:0] LAST = 5'(PACKET_CYCLES - 1);

  if (FIT < 1) begin : g_fit_chk
    $error("island window cannot hold a single packet");
  end
  if (NUM_REQ < 1 || NUM_REQ > 8 || PACKET_CYCLES != 32 || ISLAND_END > FRAME_WIDTH) begin : g_par_chk
    $error("unsupported island scheduler parameters");
  end

  typedef enum logic [2:0] {
    CONTROL     = 3'd0,
    PREAMBLE    = 3'd1,
    LEAD_GUARD  = 3'd2,
    PACKET      = 3'd3,
    TRAIL_GUARD = 3'd4
  } mode_e;

  mode_e              mode_q, mode_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0] sel_q, sel_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [4:0]         pkt_q, pkt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [4:0]         pc_q, pc_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] win_oh;
  logic [PW-1:0]      win_nxt;
  logic               take;
  int                 j;

  // round-robin pick: lowest offset from the pointer wins, so scan offsets high to low and keep the last hit
  always_comb begin
    win_oh = '0;
    win_nxt = ptr_q;
    j = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = (int'(ptr_q) + i) % NUM_REQ;
      if (bus.req[PW'(j)]) begin
        win_oh = '0;
        win_oh[PW'(j)] = 1'b1;
        win_nxt = j == NUM_REQ - 1 ? '0 : PW'(j + 1);
      end
    end
  end

  // island sequencer: phase counter, packet continuation, winner latch and registered output staging
  always_comb begin
    mode_d = mode_q;
    cnt_d = cnt_q + 5'd1;
    sel_d = sel_q;
    ptr_d = ptr_q;
    pkt_d = pkt_q;
    take = 1'b0;
    case (mode_q)
      CONTROL: begin
        cnt_d = '0;
        if (bus.cx == START && |bus.req) begin
          mode_d = PREAMBLE;
          pkt_d = '0;
          take = 1'b1;
        end
      end
      PREAMBLE: if (cnt_q == 5'd7) begin
        mode_d = LEAD_GUARD;
        cnt_d = '0;
      end
      LEAD_GUARD: if (cnt_q == 5'd1) begin
        mode_d = PACKET;
        cnt_d = '0;
      end
      PACKET: if (cnt_q == LAST) begin
        cnt_d = '0;
        take = |bus.req && pkt_q < FIT_N;
        mode_d = take ? PACKET : TRAIL_GUARD;
      end
      TRAIL_GUARD: if (cnt_q == 5'd1) begin
        mode_d = CONTROL;
        cnt_d = '0;
      end
      default: begin
        mode_d = CONTROL;
        cnt_d = '0;
      end
    endcase
    if (take) begin
      sel_d = win_oh;
      ptr_d = win_nxt;
      pkt_d = pkt_d + 5'd1;
    end
    grant_d = mode_d == PACKET ? sel_d : '0;
    ack_d = cnt_d == '0 ? grant_d : '0;
    pc_d = mode_d == PACKET ? cnt_d : '0;
    busy_d = mode_d != CONTROL;
  end

  // state and output registers; reset aborts any island in progress
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      mode_q <= CONTROL;
      cnt_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
      pkt_q <= '0;
      grant_q <= '0;
      ack_q <= '0;
      pc_q <= '0;
      busy_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      pkt_q <= pkt_d;
      grant_q <= grant_d;
      ack_q <= ack_d;
      pc_q <= pc_d;
      busy_q <= busy_d;
    end
  end

  assign bus.mode = mode_q;
  assign bus.grant = grant_q;
  assign bus.ack = ack_q;
  assign bus.packet_cycle = pc_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// tb_hdmi_island_scheduler: timeline reference model feeding a scoreboard checked by an independent monitor
module tb_hdmi_island_scheduler;
  localparam int N = 4;
  localparam int START = 644;
  localparam int FIT = 3;

  typedef struct packed {
    int         at;
    logic [3:0] oh;
  } ack_t;

  logic clk_pixel = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int t0 = -1;
  int npk = 0;
  int rr = 0;
  int src[FIT];
  logic [16:0] exp_q[$];
  ack_t ack_q[$];

  hdmi_island_scheduler_if #(.NUM_REQ(N)) bus ();
  hdmi_island_scheduler #(.NUM_REQ(N)) dut (.clk_pixel(clk_pixel), .reset(reset), .bus(bus));

  always #5 clk_pixel = ~clk_pixel;

  always @(posedge clk_pixel) cyc <= cyc + 1;

  function automatic int pick(input logic [3:0] r);
    for (int i = 0; i < N; i++) begin
      int k = (rr + i) % N;
      if (r[k]) begin
        rr = (k + 1) % N;
        return k;
      end
    end
    return 0;
  endfunction

  // reference: outputs follow from offsets relative to the trigger cycle and the list of packets decided so far
  always @(negedge clk_pixel) begin
    logic [2:0] m;
    logic [3:0] g;
    logic [4:0] pc;
    int d, w;
    m = 0;
    g = 0;
    pc = 0;
    if (reset) begin
      t0 = -1;
      npk = 0;
      rr = 0;
      ack_q.delete();
    end else begin
      if (t0 >= 0) begin
        d = cyc - t0;
        if (d <= 8) m = 1;
        else if (d <= 10) m = 2;
        else if (d < 11 + 32 * npk) begin
          m = 3;
          pc = 5'((d - 11) % 32);
          g = 4'(1 << src[(d - 11) / 32]);
        end else if (d < 13 + 32 * npk) m = 4;
        else t0 = -1;
        if (m == 3 && pc == 31 && bus.req != 0 && npk < FIT) begin
          w = pick(bus.req);
          src[npk] = w;
          npk++;
          ack_q.push_back('{at: cyc + 1, oh: 4'(1 << w)});
        end
      end
      if (t0 < 0 && bus.cx == 10'(START) && bus.req != 0) begin
        t0 = cyc;
        w = pick(bus.req);
        src[0] = w;
        npk = 1;
        ack_q.push_back('{at: cyc + 11, oh: 4'(1 << w)});
      end
    end
    exp_q.push_back({m, g, (m == 3 && pc == 0) ? g : 4'b0, pc, m != 0});
  end

  // monitor: every cycle compares the outputs; each ack pulse is matched against the next expected grant event
  always @(negedge clk_pixel) begin
    logic [16:0] a, e;
    ack_t x;
    #1;
    a = {bus.mode, bus.grant, bus.ack, bus.packet_cycle, bus.busy};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL outputs cyc=%0d: no expectation queued, got %h", cyc, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        fails++;
        $display("FAIL outputs cyc=%0d got mode=%0d grant=%b ack=%b pc=%0d busy=%b want mode=%0d grant=%b ack=%b pc=%0d busy=%b",
                 cyc, a[16:14], a[13:10], a[9:6], a[5:1], a[0], e[16:14], e[13:10], e[9:6], e[5:1], e[0]);
      end
    end
    if (bus.ack != 0) begin
      tests++;
      if (ack_q.size() == 0) begin
        fails++;
        $display("FAIL ack cyc=%0d got unexpected ack=%b, want none", cyc, bus.ack);
      end else begin
        x = ack_q.pop_front();
        if (x.at != cyc || x.oh !== bus.ack) begin
          fails++;
          $display("FAIL ack got ack=%b at cyc %0d, want ack=%b at cyc %0d", bus.ack, cyc, x.oh, x.at);
        end
      end
    end
  end

  task automatic run_line(input int kind);
    logic [3:0] r = 4'b0;
    for (int x = 0; x < 800; x++) begin
      @(posedge clk_pixel);
      #1;
      bus.cx = 10'(x);
      case (kind)
        0: r = 4'b0000;
        1: r = 4'b0010;
        2: r = 4'b1111;
        3: r = x == START ? 4'b0100 : 4'b0000;
        4: r = x > START ? 4'b0001 : 4'b0000;
        5: r = x <= 700 ? 4'b0001 : 4'b0000;
        6: r = 4'b0010;
        default: if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
      endcase
      bus.req = r;
      if (kind == 6) reset = x >= START + 20 && x < START + 23;
    end
  endtask

  task automatic do_reset();
    @(posedge clk_pixel);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk_pixel);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.cx = '0;
    bus.req = '0;
    repeat (4) @(posedge clk_pixel);
    #1;
    reset = 1'b0;
    run_line(0);
    run_line(1);
    do_reset();
    run_line(2);
    run_line(2);
    run_line(3);
    run_line(4);
    run_line(5);
    run_line(6);
    run_line(2);
    for (int l = 0; l < 12; l++) run_line(7);
    run_line(0);
    @(negedge clk_pixel);
    #2;
    tests++;
    if (ack_q.size() != 0) begin
      fails++;
      $display("FAIL pending_acks got %0d outstanding, want 0", ack_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
